// File: rtl/plru_pkg.sv
// Shared types and sizing helpers for the tree pseudo-LRU state store.
// Default-build typedefs follow DEF_WAYS / DEF_S_INDEX.
package plru_pkg;

   localparam int DEF_WAYS    = 4;
   localparam int DEF_S_INDEX = 4;

   // A binary tree over WAYS leaves has WAYS-1 internal nodes.
   function automatic int tree_width(input int ways);
      return ways - 1;
   endfunction

   typedef logic [tree_width(DEF_WAYS)-1:0] plru_tree_t;
   typedef logic [DEF_WAYS-1:0]             plru_valid_t;
   typedef logic [$clog2(DEF_WAYS)-1:0]     plru_way_t;

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational PLRU tree update (touch path) and victim selection for one set.
// Node n sits at level clog2(n+2)-1; children 2n+1 (lower half) and 2n+2 (upper half).
module plru_tree_logic #(
   parameter int WAYS = 4
) (
   input  logic [WAYS-2:0]         tree,
   input  logic [WAYS-1:0]         valid,
   input  logic [$clog2(WAYS)-1:0] touch_way,
   output logic [WAYS-2:0]         next_tree,
   output logic [$clog2(WAYS)-1:0] victim_way,
   output logic                    victim_inv
);

   localparam int LEVELS = $clog2(WAYS);
   localparam int WAY_W  = $clog2(WAYS);

   // A node is on the touched path when the way's top LVL bits select it; it then points away.
   for (genvar n = 0; n < WAYS - 1; n++) begin : g_node
      localparam int LVL = $clog2(n + 2) - 1;
      localparam int POS = n + 1 - (1 << LVL);
      logic on_path;
      assign on_path      = ((int'(touch_way) >> (LEVELS - LVL)) == POS);
      assign next_tree[n] = on_path ? ~touch_way[LEVELS-1-LVL] : tree[n];
   end

   // Way w is the tree victim when every node on its path points toward it.
   logic [WAYS-1:0] tree_hit;
   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [LEVELS-1:0] match;
      for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
         localparam int NODE = (1 << l) - 1 + (w >> (LEVELS - l));
         localparam bit DIR  = ((w >> (LEVELS - 1 - l)) & 1) == 1;
         assign match[l] = (tree[NODE] == DIR);
      end
      assign tree_hit[w] = &match;
   end

   logic [WAY_W-1:0] tree_way;
   logic [WAY_W-1:0] first_inv;

   always_comb begin
      tree_way  = '0;
      first_inv = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (tree_hit[w]) tree_way = w[WAY_W-1:0];
         if (!valid[w])   first_inv = w[WAY_W-1:0];
      end
   end

   assign victim_inv = ~&valid;
   assign victim_way = victim_inv ? first_inv : tree_way;

endmodule

// File: rtl/plru_tree_array.sv
// Per-set tree PLRU + valid store with touch/invalidate ports and a combinational victim query.
// Optional build macro PLRU_BYPASS_EN forwards same-cycle updates to the query outputs.
module plru_tree_array
   import plru_pkg::*;
#(
   parameter int S_INDEX = DEF_S_INDEX,
   parameter int WAYS    = DEF_WAYS
) (
   input  logic                    clk0,
   input  logic                    rst0_n,
   input  logic                    touch_valid,
   input  logic [S_INDEX-1:0]      touch_set,
   input  logic [$clog2(WAYS)-1:0] touch_way,
   input  logic                    inv_valid,
   input  logic [S_INDEX-1:0]      inv_set,
   input  logic [$clog2(WAYS)-1:0] inv_way,
   input  logic [S_INDEX-1:0]      query_set,
   output logic [$clog2(WAYS)-1:0] victim_way,
   output logic                    victim_inv,
   output logic                    set_full
);

   localparam int NUM_SETS = 2 ** S_INDEX;
   localparam int TREE_W   = tree_width(WAYS);
   localparam int WAY_W    = $clog2(WAYS);

   // No handshake: touch and invalidate are accepted on every posedge their valid is high.
   logic [TREE_W-1:0] tree_q  [NUM_SETS];
   logic [WAYS-1:0]   valid_q [NUM_SETS];

   logic [TREE_W-1:0] upd_next_tree;
   logic [WAY_W-1:0]  unused_upd_way;
   logic              unused_upd_inv;

   plru_tree_logic #(.WAYS(WAYS)) u_update (
      .tree       (tree_q[touch_set]),
      .valid      (valid_q[touch_set]),
      .touch_way  (touch_way),
      .next_tree  (upd_next_tree),
      .victim_way (unused_upd_way),
      .victim_inv (unused_upd_inv)
   );

   logic [TREE_W-1:0] q_tree;
   logic [WAYS-1:0]   q_valid;

`ifdef PLRU_BYPASS_EN
   // Touch is applied after invalidate so a same-way collision leaves the way valid.
   always_comb begin
      q_tree  = tree_q[query_set];
      q_valid = valid_q[query_set];
      if (inv_valid && inv_set == query_set) q_valid[inv_way] = 1'b0;
      if (touch_valid && touch_set == query_set) begin
         q_tree             = upd_next_tree;
         q_valid[touch_way] = 1'b1;
      end
   end
`else
   assign q_tree  = tree_q[query_set];
   assign q_valid = valid_q[query_set];
`endif

   logic [TREE_W-1:0] unused_q_next;
   logic [WAY_W-1:0]  q_way;
   logic              q_inv;

   plru_tree_logic #(.WAYS(WAYS)) u_query (
      .tree       (q_tree),
      .valid      (q_valid),
      .touch_way  ('0),
      .next_tree  (unused_q_next),
      .victim_way (q_way),
      .victim_inv (q_inv)
   );

   // Reset presents the cleared-state answer even before the first reset edge lands.
   assign victim_way = rst0_n ? q_way : '0;
   assign victim_inv = rst0_n ? q_inv : 1'b1;
   assign set_full   = rst0_n & (&q_valid);

   always_ff @(posedge clk0) begin
      if (!rst0_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            tree_q[s]  <= '0;
            valid_q[s] <= '0;
         end
      end else begin
         if (inv_valid) valid_q[inv_set][inv_way] <= 1'b0;
         if (touch_valid) begin
            tree_q[touch_set]             <= upd_next_tree;
            valid_q[touch_set][touch_way] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_plru_tree_array.sv
// Directed + randomized bench for plru_tree_array (WAYS=4, S_INDEX=4) against a range-halving PLRU model.
// Expectations follow the PLRU_BYPASS_EN build macro when it is defined.
module tb_plru_tree_array;

   localparam int WAYS  = 4;
   localparam int NSETS = 16;

   logic       clk0;
   logic       rst0_n;
   logic       touch_valid;
   logic [3:0] touch_set;
   logic [1:0] touch_way;
   logic       inv_valid;
   logic [3:0] inv_set;
   logic [1:0] inv_way;
   logic [3:0] query_set;
   logic [1:0] victim_way;
   logic       victim_inv;
   logic       set_full;

   int total;
   int passes;
   int fails;

   // Model: tree node bits per set (node 0 root) and a valid flag per way.
   bit m_tree  [NSETS][WAYS-1];
   bit m_valid [NSETS][WAYS];

   plru_tree_array #(.S_INDEX(4), .WAYS(WAYS)) dut (
      .clk0        (clk0),
      .rst0_n      (rst0_n),
      .touch_valid (touch_valid),
      .touch_set   (touch_set),
      .touch_way   (touch_way),
      .inv_valid   (inv_valid),
      .inv_set     (inv_set),
      .inv_way     (inv_way),
      .query_set   (query_set),
      .victim_way  (victim_way),
      .victim_inv  (victim_inv),
      .set_full    (set_full)
   );

   initial begin
      clk0 = 1'b0;
      forever #5 clk0 = ~clk0;
   end

   function automatic void model_clear();
      for (int s = 0; s < NSETS; s++) begin
         for (int n = 0; n < WAYS - 1; n++) m_tree[s][n] = 1'b0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
   endfunction

   // Walk the way range by halves; each node passed points to the half not containing w.
   function automatic void model_touch(input int s, input int w);
      int node = 0;
      int lo   = 0;
      int size = WAYS;
      while (size > 1) begin
         int half = size / 2;
         if (w < lo + half) begin
            m_tree[s][node] = 1'b1;
            node = 2 * node + 1;
         end else begin
            m_tree[s][node] = 1'b0;
            node = 2 * node + 2;
            lo   = lo + half;
         end
         size = half;
      end
      m_valid[s][w] = 1'b1;
   endfunction

   function automatic void model_apply(input bit tv, input int ts, input int tw,
                                       input bit iv, input int is_, input int iw);
      if (iv) m_valid[is_][iw] = 1'b0;
      if (tv) model_touch(ts, tw);
   endfunction

   function automatic void model_victim(input int s, output int v, output bit inv, output bit full);
      int node = 0;
      int lo   = 0;
      int size = WAYS;
      full = 1'b1;
      inv  = 1'b0;
      v    = 0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!m_valid[s][w]) begin
            full = 1'b0;
            inv  = 1'b1;
            v    = w;
         end
      end
      if (!inv) begin
         while (size > 1) begin
            int half = size / 2;
            if (m_tree[s][node]) begin
               node = 2 * node + 2;
               lo   = lo + half;
            end else begin
               node = 2 * node + 1;
            end
            size = half;
         end
         v = lo;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input int ev, input bit ei, input bit ef);
      check({tag, "_way"},  32'(victim_way), 32'(ev));
      check({tag, "_inv"},  32'(victim_inv), 32'(ei));
      check({tag, "_full"}, 32'(set_full),   32'(ef));
   endtask

   // One clock of stimulus; outputs are checked against the model before the posedge.
   task automatic step(input bit rst, input bit tv, input int ts, input int tw,
                       input bit iv, input int is_, input int iw, input int qs, input string tag);
      int  ev;
      bit  ei;
      bit  ef;
      rst0_n      = rst;
      touch_valid = tv;
      touch_set   = ts[3:0];
      touch_way   = tw[1:0];
      inv_valid   = iv;
      inv_set     = is_[3:0];
      inv_way     = iw[1:0];
      query_set   = qs[3:0];
      #1;
      if (!rst) begin
         check_outputs(tag, 0, 1'b1, 1'b0);
      end else begin
`ifdef PLRU_BYPASS_EN
         model_apply(tv, ts, tw, iv, is_, iw);
`endif
         model_victim(qs, ev, ei, ef);
         check_outputs(tag, ev, ei, ef);
      end
      @(posedge clk0);
      if (!rst) begin
         model_clear();
      end else begin
`ifndef PLRU_BYPASS_EN
         model_apply(tv, ts, tw, iv, is_, iw);
`endif
      end
      @(negedge clk0);
   endtask

   // Idle query of a set, compared with hand-derived constants.
   task automatic expect_now(input string tag, input int qs, input int ev, input bit ei, input bit ef);
      touch_valid = 1'b0;
      inv_valid   = 1'b0;
      query_set   = qs[3:0];
      #1;
      check_outputs(tag, ev, ei, ef);
   endtask

   initial begin
      int ts, tw, is_, iw, qs;
      bit tv, iv, rst;
      total  = 0;
      passes = 0;
      fails  = 0;
      model_clear();

      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0,  "rst0");
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 15, "rst15");
      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0,  "idle");
      expect_now("rst_q0",  0,  0, 1'b1, 1'b0);
      expect_now("rst_q15", 15, 0, 1'b1, 1'b0);

      for (int w = 0; w < WAYS; w++) step(1'b1, 1'b1, 5, w, 1'b0, 0, 0, 7, "fill");
      expect_now("filled", 5, 0, 1'b0, 1'b1);

      step(1'b1, 1'b1, 5, 0, 1'b0, 0, 0, 5, "touch0");
      expect_now("after_t0", 5, 2, 1'b0, 1'b1);
      step(1'b1, 1'b1, 5, 2, 1'b0, 0, 0, 5, "touch2");
      expect_now("after_t2", 5, 1, 1'b0, 1'b1);

      step(1'b1, 1'b0, 0, 0, 1'b1, 5, 2, 5, "inv2");
      expect_now("after_inv2", 5, 2, 1'b1, 1'b0);
      expect_now("set6_clean", 6, 0, 1'b1, 1'b0);

      step(1'b1, 1'b1, 5, 2, 1'b0, 0, 0, 5, "refill2");
      step(1'b1, 1'b1, 5, 3, 1'b1, 5, 3, 5, "same_way");
      expect_now("same_way_after", 5, 1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 5, 3, 1'b1, 5, 1, 5, "diff_way");
      expect_now("diff_way_after", 5, 1, 1'b1, 1'b0);

      // Same-cycle query of the set being touched.
      touch_valid = 1'b1;
      touch_set   = 4'd5;
      touch_way   = 2'd1;
      inv_valid   = 1'b0;
      query_set   = 4'd5;
      #1;
`ifdef PLRU_BYPASS_EN
      check_outputs("same_cycle", 2, 1'b0, 1'b1);
`else
      check_outputs("same_cycle", 1, 1'b1, 1'b0);
`endif
      @(posedge clk0);
      model_apply(1'b1, 5, 1, 1'b0, 0, 0);
      @(negedge clk0);
      expect_now("next_cycle", 5, 2, 1'b0, 1'b1);

      step(1'b0, 1'b1, 5, 2, 1'b0, 0, 0, 5, "rst_mid");
      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 5, "post_rst");
      expect_now("rst_mid_q5", 5, 0, 1'b1, 1'b0);

      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) != 0);
         tv  = ($urandom_range(0, 3) != 0);
         ts  = $urandom_range(0, 3);
         tw  = $urandom_range(0, WAYS - 1);
         iv  = ($urandom_range(0, 2) == 0);
         is_ = ($urandom_range(0, 1) == 0) ? ts : $urandom_range(0, 3);
         iw  = ($urandom_range(0, 1) == 0) ? tw : $urandom_range(0, WAYS - 1);
         qs  = ($urandom_range(0, 1) == 0) ? ts : $urandom_range(0, NSETS - 1);
         step(rst, tv, ts, tw, iv, is_, iw, qs, "rand");
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
